// File: rtl/alu_op_driver_pkg.sv
// rtl/alu_op_driver_pkg.sv - shared types and expected-result helper for the ALU command driver
package pck;

  typedef enum logic [1:0] {
    Add           = 2'd0,
    Sub           = 2'd1,
    Not_A         = 2'd2,
    ReductionOR_B = 2'd3
  } opcode_e;

  typedef struct packed {
    opcode_e          opcode;
    logic signed [3:0] a;
    logic signed [3:0] b;
  } alu_cmd_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } drv_state_e;

  // Result the ALU should produce for one operation, sign-extended to 5 bits.
  function automatic logic signed [4:0] alu_expected(opcode_e op, logic signed [3:0] a,
                                                     logic signed [3:0] b);
    logic signed [4:0] ax;
    logic signed [4:0] bx;
    logic signed [4:0] res;
    ax = {a[3], a};
    bx = {b[3], b};
    unique case (op)
      Add:           res = ax + bx;
      Sub:           res = ax - bx;
      Not_A:         res = ~ax;
      ReductionOR_B: res = {4'b0000, |b};
      default:       res = 5'sd0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/alu_op_driver_if.sv
// rtl/alu_op_driver_if.sv - command/ALU/response bundle; rsp_err exists only with ALU_OP_DRV_CHECK_EN
interface alu_op_driver_if;
  import pck::*;

  logic              cmd_valid;
  logic              cmd_ready;
  opcode_e           cmd_opcode;
  logic signed [3:0] cmd_a;
  logic signed [3:0] cmd_b;
  opcode_e           alu_opcode;
  logic signed [3:0] alu_a;
  logic signed [3:0] alu_b;
  logic signed [4:0] alu_c;
  logic              rsp_valid;
  logic              rsp_ready;
  logic signed [4:0] rsp_c;
  opcode_e           rsp_opcode;
`ifdef ALU_OP_DRV_CHECK_EN
  logic              rsp_err;
`endif

  // Host side: issues commands, models the ALU, consumes responses.
  modport master (
    output cmd_valid, cmd_opcode, cmd_a, cmd_b, alu_c, rsp_ready,
    input  cmd_ready, alu_opcode, alu_a, alu_b, rsp_valid, rsp_c, rsp_opcode
`ifdef ALU_OP_DRV_CHECK_EN
    , input rsp_err
`endif
  );

  // Driver side.
  modport slave (
    input  cmd_valid, cmd_opcode, cmd_a, cmd_b, alu_c, rsp_ready,
    output cmd_ready, alu_opcode, alu_a, alu_b, rsp_valid, rsp_c, rsp_opcode
`ifdef ALU_OP_DRV_CHECK_EN
    , output rsp_err
`endif
  );

endinterface

// File: rtl/alu_cmd_fifo.sv
// rtl/alu_cmd_fifo.sv - command FIFO with wrapping pointers and a separate occupancy count
module alu_cmd_fifo
  import pck::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  alu_cmd_t wdata,
  input  logic     pop,
  output alu_cmd_t rdata,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW + 1)'(1);

  alu_cmd_t      mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_q == CNT_FULL);
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  // Storage: written on accepted pushes only; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  // Pointers wrap modulo DEPTH; the count alone decides full/empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + CNT_ONE;
      else if (do_pop && !do_push) count_q <= count_q - CNT_ONE;
    end
  end

endmodule

// File: rtl/alu_op_driver.sv
// rtl/alu_op_driver.sv - issues buffered commands to the ALU one at a time; ALU_OP_DRV_CHECK_EN adds rsp_err
module alu_op_driver
  import pck::*;
#(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input logic            clk,
  input logic            reset,
  alu_op_driver_if.slave bus
);

  localparam int CW = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT + 1);

  alu_cmd_t          head;
  alu_cmd_t          cmd_in;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;

  drv_state_e        state_q;
  logic [CW-1:0]     cnt_q;
  opcode_e           alu_opcode_q;
  logic signed [3:0] alu_a_q;
  logic signed [3:0] alu_b_q;
  logic              rsp_valid_q;
  logic signed [4:0] rsp_c_q;
  opcode_e           rsp_opcode_q;
`ifdef ALU_OP_DRV_CHECK_EN
  logic              rsp_err_q;
`endif

  assign cmd_in = '{opcode: bus.cmd_opcode, a: bus.cmd_a, b: bus.cmd_b};
  assign push   = bus.cmd_valid && !fifo_full;
  assign pop    = (state_q == IDLE) && !fifo_empty;

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (push),
    .wdata (cmd_in),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.cmd_ready  = !fifo_full;
  assign bus.alu_opcode = alu_opcode_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_c      = rsp_c_q;
  assign bus.rsp_opcode = rsp_opcode_q;
`ifdef ALU_OP_DRV_CHECK_EN
  assign bus.rsp_err    = rsp_err_q;
`endif

  // Issue / wait-out-latency / hold-response sequencer; one operation in flight at a time.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      alu_opcode_q <= Add;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_c_q      <= '0;
      rsp_opcode_q <= Add;
`ifdef ALU_OP_DRV_CHECK_EN
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            alu_opcode_q <= head.opcode;
            alu_a_q      <= head.a;
            alu_b_q      <= head.b;
            cnt_q        <= CW'(ALU_LAT);
            state_q      <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            rsp_c_q      <= bus.alu_c;
            rsp_opcode_q <= alu_opcode_q;
            rsp_valid_q  <= 1'b1;
`ifdef ALU_OP_DRV_CHECK_EN
            rsp_err_q    <= (bus.alu_c != alu_expected(alu_opcode_q, alu_a_q, alu_b_q));
`endif
            state_q      <= RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
`ifdef ALU_OP_DRV_CHECK_EN
            rsp_err_q   <= 1'b0;
`endif
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_driver.sv
// tb/tb_alu_op_driver.sv - self-checking bench for alu_op_driver (ALU_OP_DRV_CHECK_EN enables checker steps)
module tb_alu_op_driver;
  import pck::*;

  localparam int DEPTH   = 4;
  localparam int ALU_LAT = 1;

  typedef struct {
    opcode_e           op;
    logic signed [4:0] c;
    logic              err;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   corrupt = 1'b0;
  bit   rnd_ready = 1'b0;
  exp_t exp_q[$];
  logic signed [4:0] alu_pipe [ALU_LAT];

  always #5 clk = ~clk;

  alu_op_driver_if bus ();

  alu_op_driver #(.DEPTH(DEPTH), .ALU_LAT(ALU_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Arithmetic meaning of each opcode on integer operands.
  function automatic int ref_c(opcode_e op, int a, int b);
    case (op)
      Add:     return a + b;
      Sub:     return a - b;
      Not_A:   return -a - 1;
      default: return (b != 0) ? 1 : 0;
    endcase
  endfunction

  // ALU stand-in: ALU_LAT register stages from A/B/Opcode to C.
  always @(posedge clk) begin
    alu_pipe[0] <= 5'(ref_c(bus.alu_opcode, int'(bus.alu_a), int'(bus.alu_b)));
    for (int k = 1; k < ALU_LAT; k++) alu_pipe[k] <= alu_pipe[k-1];
  end
  assign bus.alu_c = corrupt ? 5'sd0 : alu_pipe[ALU_LAT-1];

  task automatic chk(string tag, logic signed [31:0] got, logic signed [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Response scoreboard: every accepted response must match the oldest outstanding command.
  always @(negedge clk) begin : rsp_mon
    exp_t e;
    if (reset && bus.rsp_valid && bus.rsp_ready) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_rsp got=%0d exp=none", bus.rsp_c);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("rsp_c", bus.rsp_c, e.c);
        chk("rsp_opcode", bus.rsp_opcode, e.op);
`ifdef ALU_OP_DRV_CHECK_EN
        chk("rsp_err", bus.rsp_err, e.err);
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) bus.rsp_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(opcode_e op, int a, int b);
    exp_t              e;
    bit                done;
    logic signed [3:0] a4;
    logic signed [3:0] b4;
    a4   = 4'(a);
    b4   = 4'(b);
    done = 1'b0;
    bus.cmd_valid  = 1'b1;
    bus.cmd_opcode = op;
    bus.cmd_a      = a4;
    bus.cmd_b      = b4;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        e.op  = op;
        e.c   = corrupt ? 5'sd0 : 5'(ref_c(op, int'(a4), int'(b4)));
        e.err = corrupt;
        exp_q.push_back(e);
        done = 1'b1;
      end
      tick();
    end
    bus.cmd_valid = 1'b0;
    if (!done) chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    rnd_ready     = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int n = 0; n < 400 && (exp_q.size() != 0 || bus.rsp_valid); n++) tick();
    chk("drain_pending", exp_q.size(), 0);
    chk("drain_idle", bus.rsp_valid, 0);
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_cmd_ready"}, bus.cmd_ready, 1);
    chk({tag, "_alu_opcode"}, bus.alu_opcode, Add);
    chk({tag, "_alu_a"}, bus.alu_a, 0);
    chk({tag, "_alu_b"}, bus.alu_b, 0);
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    chk({tag, "_rsp_c"}, bus.rsp_c, 0);
    chk({tag, "_rsp_opcode"}, bus.rsp_opcode, Add);
`ifdef ALU_OP_DRV_CHECK_EN
    chk({tag, "_rsp_err"}, bus.rsp_err, 0);
`endif
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    exp_t              e;
    logic signed [4:0] held_c;

    bus.cmd_valid  = 1'b0;
    bus.cmd_opcode = Add;
    bus.cmd_a      = '0;
    bus.cmd_b      = '0;
    bus.rsp_ready  = 1'b1;

    // Reset state
    #12;
    chk_reset_outputs("reset");
    tick();
    reset = 1'b1;
    tick();

    // Single add with exact latency
    bus.cmd_valid  = 1'b1;
    bus.cmd_opcode = Add;
    bus.cmd_a      = 4'sd3;
    bus.cmd_b      = 4'sd4;
    e.op = Add; e.c = 5'sd7; e.err = 1'b0;
    exp_q.push_back(e);
    tick();
    bus.cmd_valid = 1'b0;
    chk("lat_e0_alu_a", bus.alu_a, 0);
    tick();
    chk("lat_e1_alu_a", bus.alu_a, 3);
    chk("lat_e1_alu_b", bus.alu_b, 4);
    chk("lat_e1_rsp_valid", bus.rsp_valid, 0);
    tick();
    chk("lat_e2_rsp_valid", bus.rsp_valid, 0);
    tick();
    chk("lat_e3_rsp_valid", bus.rsp_valid, 1);
    chk("lat_e3_rsp_c", bus.rsp_c, 7);
    drain();

    // Signed extremes
    send(Sub, -8, 7);
    send(Add, -8, -8);
    send(Not_A, 3, 0);
    send(ReductionOR_B, 0, 0);
    send(ReductionOR_B, 0, -1);
    drain();

    // Backpressure: five commands, four buffered plus one in flight
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(Add, i, i);
    chk("bp_cmd_ready_full", bus.cmd_ready, 0);
    chk("bp_rsp_valid", bus.rsp_valid, 1);
    held_c = bus.rsp_c;
    bus.cmd_valid  = 1'b1;
    bus.cmd_opcode = Sub;
    bus.cmd_a      = 4'sd1;
    bus.cmd_b      = 4'sd1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_ready", bus.cmd_ready, 0);
      chk("bp_hold_valid", bus.rsp_valid, 1);
      chk("bp_hold_c", bus.rsp_c, held_c);
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();
    chk("bp_ready_before_pop", bus.cmd_ready, 0);
    tick();
    chk("bp_ready_after_pop", bus.cmd_ready, 1);
    drain();

    // Reset between issue and capture
    send(Add, 5, 5);
    tick();
    chk("rst_issued_a", bus.alu_a, 5);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_outputs("rst_mid");
    exp_q.delete();
    tick();
    tick();
    chk("rst_held_valid", bus.rsp_valid, 0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_after_valid", bus.rsp_valid, 0);
    end
    send(Add, 1, 1);
    drain();

    // Pointer wrap: ten back-to-back commands
    for (int i = 0; i < 10; i++) send(Add, i, 1);
    drain();

    // Random commands with random response backpressure
    rnd_ready = 1'b1;
    for (int i = 0; i < 24; i++)
      send(opcode_e'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
           int'($urandom_range(0, 15)));
    drain();

`ifdef ALU_OP_DRV_CHECK_EN
    // Result checker: corrupted ALU output, then clean
    corrupt = 1'b1;
    send(Add, 2, 2);
    drain();
    corrupt = 1'b0;
    send(Add, 2, 2);
    drain();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
